// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one variable-latency memory
// port between instruction fetch (port A) and load/store (port B). Only one
// transaction is in flight at a time. A watchdog aborts accesses that stall
// for TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [1:0]        a_size,
  output logic              a_busy,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_size,
  output logic              b_busy,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state_q;
  logic              owner_q;    // 0 = A, 1 = B
  logic              prio_q;     // 0 = A wins a tie, 1 = B wins a tie
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              a_busy_q, a_done_q, a_err_q;
  logic              b_busy_q, b_done_q, b_err_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              mem_re_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        mem_size_q;

  logic              a_elig_s, b_elig_s, grant_s, grant_b_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [1:0]        sel_size_s;
  logic              timeout_s;
  logic              finish_s;
  logic [DATA_W-1:0] fin_rdata_s;

  // Arbitration and completion decode; a requester whose done pulse is up
  // this cycle is still holding its old request and must not be re-granted.
  always_comb begin
    a_elig_s = a_req & ~a_done_q;
    b_elig_s = b_req & ~b_done_q;
    grant_s  = a_elig_s | b_elig_s;
    if (a_elig_s && b_elig_s) begin
      grant_b_s = prio_q;
    end else begin
      grant_b_s = b_elig_s;
    end
    if (grant_b_s) begin
      sel_we_s    = b_we;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
      sel_size_s  = b_size;
    end else begin
      sel_we_s    = a_we;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
      sel_size_s  = a_size;
    end
    timeout_s = WDOG_EN & (cnt_q == CNT_LAST);
    finish_s  = mem_ready | timeout_s;
    if (mem_ready && !we_q) begin
      fin_rdata_s = mem_rdata;
    end else begin
      fin_rdata_s = {DATA_W{1'b0}};
    end
  end

  // Arbiter FSM; every output is a register that is loaded on grant and
  // cleared on completion, so the memory port is all-zero while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      a_busy_q    <= 1'b0;
      a_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      a_rdata_q   <= {DATA_W{1'b0}};
      b_busy_q    <= 1'b0;
      b_done_q    <= 1'b0;
      b_err_q     <= 1'b0;
      b_rdata_q   <= {DATA_W{1'b0}};
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_size_q  <= 2'b00;
    end else begin
      a_done_q <= 1'b0;
      a_err_q  <= 1'b0;
      b_done_q <= 1'b0;
      b_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            state_q     <= ST_BUSY;
            owner_q     <= grant_b_s;
            we_q        <= sel_we_s;
            cnt_q       <= {CNT_W{1'b0}};
            a_busy_q    <= ~grant_b_s;
            b_busy_q    <= grant_b_s;
            mem_re_q    <= ~sel_we_s;
            mem_we_q    <= sel_we_s;
            mem_addr_q  <= sel_addr_s;
            mem_wdata_q <= sel_wdata_s;
            mem_size_q  <= sel_size_s;
          end
        end
        ST_BUSY: begin
          if (finish_s) begin
            state_q     <= ST_IDLE;
            prio_q      <= ~owner_q;
            cnt_q       <= {CNT_W{1'b0}};
            a_busy_q    <= 1'b0;
            b_busy_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_size_q  <= 2'b00;
            if (owner_q) begin
              b_done_q  <= 1'b1;
              b_err_q   <= ~mem_ready;
              b_rdata_q <= fin_rdata_s;
            end else begin
              a_done_q  <= 1'b1;
              a_err_q   <= ~mem_ready;
              a_rdata_q <= fin_rdata_s;
            end
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_busy    = a_busy_q;
  assign a_done    = a_done_q;
  assign a_err     = a_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_busy    = b_busy_q;
  assign b_done    = b_done_q;
  assign b_err     = b_err_q;
  assign b_rdata   = b_rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single data_memory port (incl. its memory-mapped serial window) between instruction fetch (port A) and load/store (port B).
- Used once the core moves to multi-cycle fetch from data memory.
- Round-robin priority, one outstanding transaction at a time, variable-latency memory via mem_ready, watchdog timeout for stalled serial accesses.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width
TIMEOUT, 16, max BUSY cycles without mem_ready before abort; 0 disables the watchdog

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
a_req  in  1  port A request; held high with fields stable until a_done
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_size  in  2  port A access size, passed through
a_busy  out  1  high while A owns the memory port
a_done  out  1  one-cycle completion pulse for A
a_err  out  1  valid with a_done; 1 = timed out
a_rdata  out  DATA_W  read data, valid with a_done, held until the next A completion
b_req, b_we, b_addr, b_wdata, b_size, b_busy, b_done, b_err, b_rdata: identical roles for port B
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_size  out  2  memory access size
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes the current access this cycle

Behaviour:
- Reset (reset=0, async): state IDLE, priority pointer = A, timeout counter 0, all outputs 0 including rdata registers. Reset during BUSY aborts the transaction; no done pulse is issued.
- States: IDLE, BUSY.
- IDLE:
  - Eligible requester = req high and its done not high this cycle. This masks the held req in the cycle done is seen.
  - One eligible: grant it.
  - Both eligible: grant the priority pointer's port.
  - On grant, at the next edge: latch owner id, we, addr, wdata, size into internal registers; counter 0; state BUSY.
- BUSY:
  - mem_re = ~we_l, mem_we = we_l; mem_addr/mem_wdata/mem_size driven from the latched registers only. Requester field changes during BUSY are ignored.
  - owner_busy = 1.
  - If mem_ready=1 at an edge: owner_done=1, owner_err=0 and owner_rdata <= mem_rdata for the following cycle (writes: rdata <= 0); state IDLE; priority pointer <= non-owner.
  - Else if TIMEOUT!=0 and counter == TIMEOUT-1: same exit, except err=1 and rdata=0.
  - Else counter+1.
- In IDLE all mem_* outputs are 0.
- Latency:
  - req high in cycle 0 → BUSY cycles 1..n → done in cycle n+1, where n = the first BUSY cycle with mem_ready=1.
  - Minimum: done in cycle 2.
  - Back-to-back: next grant is decided in the done cycle, so the next BUSY starts the cycle after done.
- Fairness: with both requesting continuously, grants strictly alternate A,B,A,B.
- mem_ready while IDLE is ignored.
- done/err are never high for both ports in the same cycle.
- busy and done of one port are never high in the same cycle.

Test Plan:
- Reset then a_req=1 read, addr 0x00400000, mem_ready=1 in first BUSY cycle, mem_rdata=0x8C010004 → mem_re high cycle 1 only; a_done=1, a_rdata=0x8C010004, a_err=0 in cycle 2; b_* stay 0.
- a_req and b_req both asserted from cycle 0, mem_ready always 1 → BUSY owners A,B,A,B; done pulses alternate, each separated by one BUSY cycle.
- b_req write, addr 0xFFFF0004, wdata 0x41, mem_ready held low 3 cycles → mem_we high 4 cycles with constant addr/data; b_done in the cycle after ready; b_err=0.
- TIMEOUT=16, a_req read with mem_ready stuck 0 → exactly 16 BUSY cycles; a_done=1, a_err=1, a_rdata=0; next request is then served normally.
- reset driven 0 in the 2nd BUSY cycle of a B read → all outputs 0 immediately (async); no b_done after reset release; priority returns to A.
- Owner changes a_addr mid-BUSY from 0x10 to 0x20 → mem_addr stays 0x10 through completion.
